// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-sequencing state encoding and default payload width.
// Kept separate so a receiver can reuse the same state names and width default.
package uart_pkg;

  // Default payload width; frames carry 5..8 data bits.
  localparam int UART_DATA_BITS     = 8;
  localparam int UART_DATA_BITS_MIN = 5;
  localparam int UART_DATA_BITS_MAX = 8;

  // Frame sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: serialises one payload per frame (start, data LSB first,
// optional parity, one or two stop bits), pacing every bit on an external
// baud tick. A one-entry pending register accepts the next frame during the
// final stop bit so frames can run back to back with no idle gap.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | line high, waiting for a transfer
//   ARMED  | frame latched, waiting for the first tick to open the start bit
//   START  | start bit (line low)
//   DATA   | payload bits, bit_cnt selects the bit on the line
//   PARITY | parity bit (only when enabled for this frame)
//   STOP   | stop bit(s), line high; final stop may accept the next frame
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_baud_tick,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  input  logic                 i_two_stop,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int              CNT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  uart_state_e state;
  uart_state_e state_nx;

  // Frame currently on the line.
  logic [DATA_BITS-1:0] data_q;
  logic                 par_en_q;
  logic                 par_odd_q;
  logic                 two_stop_q;

  // Next frame, captured during the final stop bit.
  logic                 pend_valid;
  logic [DATA_BITS-1:0] pend_data;
  logic                 pend_par_en;
  logic                 pend_par_odd;
  logic                 pend_two_stop;

  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     bit_nx;
  logic                 stop_cnt;

  logic                 final_stop;
  logic                 end_tick;
  logic                 ready;
  logic                 xfer;
  logic                 parity_bit;
  logic                 tx_nx;

  // The final stop bit is the only stop when one is configured, otherwise the second.
  assign final_stop = (state == ST_STOP) && (!two_stop_q || stop_cnt);
  assign end_tick   = final_stop && i_baud_tick;

  // Ready is held low during reset so nothing is offered before the block is live.
  assign ready   = !i_rst && ((state == ST_IDLE) || (final_stop && !pend_valid));
  assign xfer    = i_valid && ready;
  assign o_ready = ready;

  assign parity_bit = (^data_q) ^ par_odd_q;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; everything after ARMED advances only on a baud tick.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        // A tick coinciding with the transfer is deliberately ignored.
        if (xfer) state_nx = ST_ARMED;
      end
      ST_ARMED: begin
        if (i_baud_tick) state_nx = ST_START;
      end
      ST_START: begin
        if (i_baud_tick) state_nx = ST_DATA;
      end
      ST_DATA: begin
        if (i_baud_tick && (bit_cnt == LAST_BIT)) begin
          state_nx = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (i_baud_tick) state_nx = ST_STOP;
      end
      ST_STOP: begin
        if (end_tick) begin
          state_nx = (pend_valid || xfer) ? ST_START : ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output logic: line value for the state being entered, so it is registered
  // on the same edge as the state change.
  always_comb begin
    bit_nx = bit_cnt;
    tx_nx  = 1'b1;
    if (state == ST_START) begin
      bit_nx = '0;
    end else if ((state == ST_DATA) && i_baud_tick) begin
      bit_nx = bit_cnt + 1'b1;
    end
    unique case (state_nx)
      ST_START:  tx_nx = 1'b0;
      ST_DATA:   tx_nx = data_q[bit_nx];
      ST_PARITY: tx_nx = parity_bit;
      default:   tx_nx = 1'b1;
    endcase
  end

  // Frame latch, pending register and bit/stop counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q        <= '0;
      par_en_q      <= 1'b0;
      par_odd_q     <= 1'b0;
      two_stop_q    <= 1'b0;
      pend_valid    <= 1'b0;
      pend_data     <= '0;
      pend_par_en   <= 1'b0;
      pend_par_odd  <= 1'b0;
      pend_two_stop <= 1'b0;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
    end else begin
      if (xfer && ((state == ST_IDLE) || end_tick)) begin
        data_q     <= i_data;
        par_en_q   <= i_parity_en;
        par_odd_q  <= i_parity_odd;
        two_stop_q <= i_two_stop;
      end else if (end_tick && pend_valid) begin
        data_q     <= pend_data;
        par_en_q   <= pend_par_en;
        par_odd_q  <= pend_par_odd;
        two_stop_q <= pend_two_stop;
      end

      if (end_tick) begin
        pend_valid <= 1'b0;
      end else if (xfer && (state == ST_STOP)) begin
        pend_valid    <= 1'b1;
        pend_data     <= i_data;
        pend_par_en   <= i_parity_en;
        pend_par_odd  <= i_parity_odd;
        pend_two_stop <= i_two_stop;
      end

      if ((state == ST_START) && i_baud_tick) begin
        bit_cnt <= '0;
      end else if ((state == ST_DATA) && i_baud_tick && (bit_cnt != LAST_BIT)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (state != ST_STOP) begin
        stop_cnt <= 1'b0;
      end else if (i_baud_tick) begin
        stop_cnt <= 1'b1;
      end
    end
  end

  // Registered line, busy and end-of-frame pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tx   <= 1'b1;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_tx   <= tx_nx;
      o_busy <= (state_nx != ST_IDLE);
      o_done <= end_tick;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: baud tick every 10 clocks, line checked every cycle.
module tb_uart_tx;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_baud_tick;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       i_parity_en;
  logic       i_parity_odd;
  logic       i_two_stop;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [7:0] nxt_d;
  logic       nxt_pe, nxt_po, nxt_ts;

  uart_tx #(.DATA_BITS(8)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_baud_tick  (i_baud_tick),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_parity_en  (i_parity_en),
    .i_parity_odd (i_parity_odd),
    .i_two_stop   (i_two_stop),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given tick value; outputs are read 1 ns after the edge.
  task automatic step(input logic tk);
    i_baud_tick = tk;
    @(posedge i_clk);
    #1;
    i_baud_tick = 1'b0;
    if (o_done) done_cnt++;
  endtask

  // Expected line bits: [0] start, then data LSB first, parity, stop(s).
  function automatic logic [15:0] frame_vec(input logic [7:0] d, input logic pe, input logic po);
    logic [15:0] v;
    v    = '1;
    v[0] = 1'b0;
    for (int i = 0; i < 8; i++) v[1+i] = d[i];
    if (pe) v[9] = (^d) ^ po;
    return v;
  endfunction

  function automatic int frame_len(input logic pe, input logic ts);
    return 10 + int'(pe) + int'(ts);
  endfunction

  task automatic send(input logic [7:0] d, input logic pe, input logic po, input logic ts,
                      input logic tk);
    i_data = d; i_parity_en = pe; i_parity_odd = po; i_two_stop = ts;
    i_valid = 1'b1;
    step(tk);
    i_valid = 1'b0;
    // Scramble inputs to prove the frame was latched.
    i_data = ~d; i_parity_en = ~pe; i_parity_odd = ~po; i_two_stop = ~ts;
    check_eq("busy after accept", o_busy, 1);
    check_eq("ready after accept", o_ready, 0);
    check_eq("tx after accept", o_tx, 1);
  endtask

  // One bit period: tick cycle plus nine quiet cycles; optional offer of nxt_* at cycle offer_at.
  task automatic bit_period(input string tag, input logic exp_tx, input int offer_at,
                            input logic exp_rdy);
    step(1'b1);
    check_eq({tag, " tx@tick"}, o_tx, exp_tx);
    check_eq({tag, " done@tick"}, o_done, 0);
    check_eq({tag, " busy"}, o_busy, 1);
    for (int c = 1; c < 10; c++) begin
      if (c == offer_at) begin
        check_eq({tag, " ready at offer"}, o_ready, exp_rdy);
        i_data = nxt_d; i_parity_en = nxt_pe; i_parity_odd = nxt_po; i_two_stop = nxt_ts;
        i_valid = 1'b1;
      end
      step(1'b0);
      i_valid = 1'b0;
      check_eq({tag, " tx hold"}, o_tx, exp_tx);
      check_eq({tag, " done hold"}, o_done, 0);
    end
  endtask

  task automatic play(input string tag, input logic [15:0] v, input int first, input int last,
                      input int offer_idx, input int offer_at, input logic exp_rdy);
    for (int i = first; i <= last; i++) begin
      bit_period(tag, v[i], (i == offer_idx) ? offer_at : -1, exp_rdy);
    end
  endtask

  task automatic frame_end(input string tag, input logic exp_busy, input logic exp_tx);
    step(1'b1);
    check_eq({tag, " done pulse"}, o_done, 1);
    check_eq({tag, " busy at end"}, o_busy, exp_busy);
    check_eq({tag, " tx at end"}, o_tx, exp_tx);
  endtask

  task automatic idle_after(input string tag);
    step(1'b0);
    check_eq({tag, " done one cycle"}, o_done, 0);
    check_eq({tag, " ready idle"}, o_ready, 1);
    check_eq({tag, " busy idle"}, o_busy, 0);
  endtask

  task automatic full_frame(input string tag, input logic [7:0] d, input logic pe,
                            input logic po, input logic ts);
    logic [15:0] v;
    int          n;
    int          d0;
    v  = frame_vec(d, pe, po);
    n  = frame_len(pe, ts);
    d0 = done_cnt;
    send(d, pe, po, ts, 1'b0);
    play(tag, v, 0, n - 1, -1, -1, 1'b0);
    frame_end(tag, 1'b0, 1'b1);
    idle_after(tag);
    check_eq({tag, " done count"}, done_cnt - d0, 1);
  endtask

  initial begin
    logic [15:0] va, vb;
    int          d0;

    i_rst = 1'b1; i_baud_tick = 1'b0; i_data = 8'h00; i_valid = 1'b0;
    i_parity_en = 1'b0; i_parity_odd = 1'b0; i_two_stop = 1'b0;
    nxt_d = 8'h00; nxt_pe = 1'b0; nxt_po = 1'b0; nxt_ts = 1'b0;

    // Reset values and first-cycle ready.
    step(1'b0);
    step(1'b1);
    check_eq("rst tx", o_tx, 1);
    check_eq("rst busy", o_busy, 0);
    check_eq("rst done", o_done, 0);
    check_eq("rst ready", o_ready, 0);
    i_rst = 1'b0;
    #1;
    check_eq("ready after rst", o_ready, 1);
    step(1'b0);

    // 0x55 8N1, with an ignored offer (0xFF, parity) in the middle of the data.
    va = frame_vec(8'h55, 1'b0, 1'b0);
    check_eq("0x55 line pattern", va[9:0], 10'b10_1010_1010);
    d0 = done_cnt;
    nxt_d = 8'hFF; nxt_pe = 1'b1; nxt_po = 1'b1; nxt_ts = 1'b1;
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    play("8N1 55", va, 0, 9, 4, 5, 1'b0);
    frame_end("8N1 55", 1'b0, 1'b1);
    idle_after("8N1 55");
    check_eq("8N1 55 done count", done_cnt - d0, 1);
    for (int i = 0; i < 20; i++) step(i % 10 == 0);
    check_eq("no stray frame tx", o_tx, 1);
    check_eq("no stray frame busy", o_busy, 0);
    check_eq("no stray frame done", done_cnt - d0, 1);

    // 0xA3 with even then odd parity.
    vb = frame_vec(8'hA3, 1'b1, 1'b0);
    check_eq("A3 data bits", vb[8:1], 8'b1010_0011);
    check_eq("A3 even parity", vb[9], 0);
    full_frame("8E1 A3", 8'hA3, 1'b1, 1'b0, 1'b0);
    full_frame("8O1 A3", 8'hA3, 1'b1, 1'b1, 1'b0);

    // Two stop bits: 11 bit periods before done.
    full_frame("8N2 3C", 8'h3C, 1'b0, 1'b0, 1'b1);

    // Back to back: 0x12 8N1 then 0xC5 8E1 offered in the final stop bit.
    va = frame_vec(8'h12, 1'b0, 1'b0);
    vb = frame_vec(8'hC5, 1'b1, 1'b0);
    d0 = done_cnt;
    nxt_d = 8'hC5; nxt_pe = 1'b1; nxt_po = 1'b0; nxt_ts = 1'b0;
    send(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    play("b2b A", va, 0, 8, -1, -1, 1'b0);
    play("b2b A stop", va, 9, 9, 9, 4, 1'b1);
    check_eq("b2b ready after pend", o_ready, 0);
    frame_end("b2b A", 1'b1, 1'b0);
    for (int c = 1; c < 10; c++) begin
      step(1'b0);
      check_eq("b2b B start hold", o_tx, 0);
      check_eq("b2b B busy", o_busy, 1);
    end
    play("b2b B", vb, 1, 10, -1, -1, 1'b0);
    frame_end("b2b B", 1'b0, 1'b1);
    idle_after("b2b B");
    check_eq("b2b done count", done_cnt - d0, 2);

    // Transfer coincident with a tick: start waits for the next tick.
    va = frame_vec(8'h81, 1'b0, 1'b0);
    d0 = done_cnt;
    send(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c < 10; c++) begin
      step(1'b0);
      check_eq("coinc tick armed tx", o_tx, 1);
    end
    play("coinc 81", va, 0, 9, -1, -1, 1'b0);
    frame_end("coinc 81", 1'b0, 1'b1);
    idle_after("coinc 81");
    check_eq("coinc done count", done_cnt - d0, 1);

    // Reset in the middle of a 0x00 frame, then a fresh 0x0F frame.
    va = frame_vec(8'h00, 1'b0, 1'b0);
    d0 = done_cnt;
    send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    play("pre rst", va, 0, 2, -1, -1, 1'b0);
    step(1'b1);
    step(1'b0);
    check_eq("mid data tx low", o_tx, 0);
    i_rst = 1'b1;
    step(1'b0);
    check_eq("mid rst tx", o_tx, 1);
    check_eq("mid rst busy", o_busy, 0);
    check_eq("mid rst done", o_done, 0);
    check_eq("mid rst ready", o_ready, 0);
    step(1'b1);
    i_rst = 1'b0;
    #1;
    check_eq("mid rst ready after", o_ready, 1);
    for (int i = 0; i < 12; i++) step(i % 10 == 0);
    check_eq("mid rst line idle", o_tx, 1);
    check_eq("mid rst no done", done_cnt - d0, 0);
    full_frame("post rst 0F", 8'h0F, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: DATA_BITS, 8, payload bits per frame (legal 5..8).
REQ-002 SHALL have port: i_clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port: i_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: i_baud_tick  input  1  one-cycle strobe, driven by baud_generator o_rising_edge, marking each bit-period boundary.
REQ-005 SHALL have port: i_data  input  DATA_BITS  payload, transmitted LSB first.
REQ-006 SHALL have port: i_valid  input  1  payload/config offered.
REQ-007 SHALL have port: o_ready  output  1  block can accept; transfer occurs when i_valid && o_ready at a rising i_clk.
REQ-008 SHALL have port: i_parity_en  input  1  append parity bit.
REQ-009 SHALL have port: i_parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-010 SHALL have port: i_two_stop  input  1  1 = two stop bits, 0 = one stop bit.
REQ-011 SHALL have port: o_tx  output  1  serial line, idle high, registered.
REQ-012 SHALL have port: o_busy  output  1  high from acceptance until the frame ends.
REQ-013 SHALL have port: o_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-014 SHALL implement FSM states IDLE, ARMED, START, DATA, PARITY, STOP.
REQ-015 SHALL, on transfer, latch i_data, i_parity_en, i_parity_odd and i_two_stop; input changes after latching SHALL NOT affect the frame.
REQ-016 SHALL move IDLE->ARMED on transfer; an i_baud_tick in the same cycle as the transfer SHALL be ignored.
REQ-017 SHALL move ARMED->START on the next i_baud_tick, with o_tx = 0 from the following cycle.
REQ-018 SHALL change state and o_tx only on i_baud_tick, so every bit lasts exactly one tick period.
REQ-019 SHALL take the path START->DATA (DATA_BITS ticks, bit counter 0..DATA_BITS-1, LSB first)->PARITY (if enabled)->STOP (1 or 2 ticks); o_tx SHALL be 1 throughout STOP.
REQ-020 SHALL drive the parity bit as XOR-reduce(data) when even, and its inverse when odd.
REQ-021 SHALL pulse o_done high for one cycle in the cycle after the tick that ends the final stop bit.
REQ-022 SHALL assert o_ready in IDLE, and in the final stop bit while the one-entry pending register is empty; it SHALL be low otherwise.
REQ-023 SHALL accept a transfer during the final stop bit into the pending register; at the end-of-stop tick the FSM SHALL go directly to START with no idle gap and o_busy staying high.
REQ-024 SHALL return to IDLE at the end-of-stop tick when nothing is pending; o_busy falls in the same cycle that o_done rises.
REQ-025 SHALL ignore i_valid while o_ready is low (no latch, no state change).
REQ-026 SHALL keep the bit counter wide enough for DATA_BITS-1 and reset it to 0 on entering DATA.

Reset
REQ-027 SHALL, while i_rst is high at a clock edge, set state IDLE, o_tx=1, o_busy=0, o_done=0, o_ready=0, counter 0 and pending cleared.
REQ-028 SHALL assert o_ready=1 in the first cycle after i_rst deasserts.
REQ-029 SHALL, on reset mid-frame, abort the frame: o_tx=1 the next cycle, pending data discarded, no o_done pulse.

Structure
REQ-030 SHALL place the FSM state enum type and the default DATA_BITS constant in shared package uart_pkg, for reuse by a future uart_rx.
REQ-031 SHALL be a single module with no sub-module; parity is an inline reduction.

Verification
REQ-032 SHALL cover: tick every 10 cycles, send 0x55 as 8N1 -> o_tx = 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles, o_done once, o_busy low afterwards.
REQ-033 SHALL cover: 0xA3 with parity even -> parity bit 0; with parity odd -> parity bit 1; data bits on the line 1,1,0,0,0,1,0,1.
REQ-034 SHALL cover: i_two_stop=1 -> o_tx high for 2 tick periods before o_done; frame length is 11 ticks (8N2).
REQ-035 SHALL cover: second transfer during the final stop bit -> its start bit follows immediately, with no extra high time between frames and o_busy continuously high.
REQ-036 SHALL cover: transfer coincident with i_baud_tick -> start bit begins at the next tick, not the coincident one.
REQ-037 SHALL cover: i_rst pulsed mid-DATA -> o_tx=1 the next cycle, no o_done, o_ready=1 after release, and a fresh 0x0F frame then transmits correctly.
